alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the operand and result width.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  2  per-requester operation valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 req0_srca, req0_srcb  input  DATA_WIDTH each  requester 0 operands.
REQ-007 req0_ctrl  input  4  requester 0 ALU control code.
REQ-008 req1_srca, req1_srcb  input  DATA_WIDTH each  requester 1 operands.
REQ-009 req1_ctrl  input  4  requester 1 ALU control code.
REQ-010 rsp_valid  output  1  response slot holds a result.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_id  output  1  requester that issued the held result.
REQ-013 rsp_result  output  DATA_WIDTH  registered ALU result.
REQ-014 rsp_zero  output  1  registered zero flag; 1 iff rsp_result == 0.

Function
REQ-015 A transfer SHALL occur on a rising edge where req_valid[i] && req_ready[i]; a requester SHALL hold operands and ctrl stable while valid && !ready.
REQ-016 slot_free SHALL equal !rsp_valid || rsp_ready.
REQ-017 req_ready[i] SHALL be slot_free && (grant == i) && req_valid[i]; it is combinational from req_valid, rsp_ready and the priority pointer.
REQ-018 Arbitration: one requester valid -> grant it; both valid -> grant the requester named by the 1-bit pointer prio.
REQ-019 After each transfer prio SHALL become the non-granted id; with no transfer prio SHALL hold.
REQ-020 The granted operands/ctrl SHALL feed one shared combinational ALU; result, zero flag and id SHALL be captured into the response slot on the transfer edge (latency 1 cycle).
REQ-021 ALU codes: 0000 add, 0001 (a!=b), 0010 b, 0011 add, 0100 {b[31:12],12'b0}, 0101 {24'b0,b[7:0]}, 0110 add, 0111 a<<b[4:0], 1000 a-b, 1001 a>>b[4:0] logical, 1010 xor, 1011 or, 1100 and, 1101 xor; all others -> 0. Add/sub SHALL wrap modulo 2^DATA_WIDTH.
REQ-022 Drain without transfer (rsp_valid && rsp_ready, no req accepted) SHALL clear rsp_valid next edge.
REQ-023 Simultaneous drain and transfer SHALL reload the slot with rsp_valid remaining 1; sustained throughput SHALL be one operation per cycle.
REQ-024 Stall (rsp_valid && !rsp_ready): req_ready SHALL be 00 and rsp_id/rsp_result/rsp_zero SHALL hold stable.
REQ-025 No valid requests and slot free: no state change except rsp_valid clearing per REQ-022.

Reset
REQ-026 On rst assertion, immediately and independent of clk: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, prio=0.
REQ-027 req_ready SHALL be 00 while rst is high.
REQ-028 Reset mid-operation SHALL discard any held result without emitting it; the first post-reset transfer SHALL start with prio=0.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit ALU control code constants (ALU_ADD, ALU_SUB, ALU_LUI, ...) and the requester-id typedef; alu_arbiter and the decoder SHALL both import it.
REQ-030 The shared ALU SHALL be a single instance of the existing alu module driven by a 2:1 operand/ctrl mux; no other sub-modules.

Verification
REQ-031 req0 only, ctrl 0000, a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-032 Both valid every cycle, rsp_ready=1, from reset -> grants 0,1,0,1; req0 ctrl 1000 a=9 b=9 -> rsp_result=0, rsp_zero=1.
REQ-033 Result held, rsp_ready=0 for 3 cycles -> req_ready=00 and rsp outputs unchanged; rsp_ready=1 on 4th cycle -> pending requester accepted that same cycle.
REQ-034 req1 only while prio=0 -> req1 granted, rsp_id=1, prio becomes 0; ctrl 0100 b=0x12345678 -> rsp_result=0x12345000.
REQ-035 ctrl 1111 any operands -> rsp_result=0, rsp_zero=1; a=0xFFFFFFFF + b=1 -> rsp_result=0, rsp_zero=1.
REQ-036 rst pulsed between clock edges while rsp_valid=1 -> rsp_valid=0 before the next edge; no response emitted for the dropped result.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, requester id type and grant helper
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_NEQ   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0010;
  localparam logic [3:0] ALU_ADD_3 = 4'b0011;
  localparam logic [3:0] ALU_LUI   = 4'b0100;
  localparam logic [3:0] ALU_BYTE  = 4'b0101;
  localparam logic [3:0] ALU_ADD_6 = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_OR    = 4'b1011;
  localparam logic [3:0] ALU_AND   = 4'b1100;
  localparam logic [3:0] ALU_XOR_D = 4'b1101;

  typedef logic req_id_t;

  // Single valid requester wins outright; on contention the pointer decides.
  function automatic req_id_t pick_grant(input logic [1:0] valid, input req_id_t prio);
    req_id_t g;
    case (valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      2'b11:   g = prio;
      default: g = prio;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational ALU decoding the 4-bit control code
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_srca,
  input  logic [DATA_WIDTH-1:0] i_srcb,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_srcb[4:0];

  // Decode the control code; unassigned codes produce zero.
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD, ALU_ADD_3, ALU_ADD_6: o_result = i_srca + i_srcb;
      ALU_NEQ:   o_result = {{(DATA_WIDTH-1){1'b0}}, (i_srca != i_srcb)};
      ALU_PASSB: o_result = i_srcb;
      ALU_LUI:   o_result = {i_srcb[DATA_WIDTH-1:12], 12'b0};
      ALU_BYTE:  o_result = {{(DATA_WIDTH-8){1'b0}}, i_srcb[7:0]};
      ALU_SLL:   o_result = i_srca << w_shamt;
      ALU_SUB:   o_result = i_srca - i_srcb;
      ALU_SRL:   o_result = i_srca >> w_shamt;
      ALU_XOR, ALU_XOR_D: o_result = i_srca ^ i_srcb;
      ALU_OR:    o_result = i_srca | i_srcb;
      ALU_AND:   o_result = i_srca & i_srcb;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end to one shared ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_srca,
  input  logic [DATA_WIDTH-1:0] req0_srcb,
  input  logic [3:0]            req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_srca,
  input  logic [DATA_WIDTH-1:0] req1_srcb,
  input  logic [3:0]            req1_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero
);

  logic                  r_rsp_valid;
  req_id_t               r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_zero;
  req_id_t               r_prio;

  req_id_t               w_grant;
  logic                  w_slot_free;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_srca;
  logic [DATA_WIDTH-1:0] w_srcb;
  logic [3:0]            w_ctrl;
  logic [DATA_WIDTH-1:0] w_alu_result;

  assign w_grant     = pick_grant(req_valid, r_prio);
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // Accept only the granted requester, only when the slot can take a result; held off in reset.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && w_slot_free) begin
      req_ready[0] = req_valid[0] && (w_grant == 1'b0);
      req_ready[1] = req_valid[1] && (w_grant == 1'b1);
    end
  end

  assign w_xfer = |req_ready;

  assign w_srca = w_grant ? req1_srca : req0_srca;
  assign w_srcb = w_grant ? req1_srcb : req0_srcb;
  assign w_ctrl = w_grant ? req1_ctrl : req0_ctrl;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_ctrl   (w_ctrl),
    .i_srca   (w_srca),
    .i_srcb   (w_srcb),
    .o_result (w_alu_result)
  );

  // Response slot: reload on transfer (also covers drain+reload), clear on plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant;
      r_rsp_result <= w_alu_result;
      r_rsp_zero   <= (w_alu_result == '0);
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Priority pointer moves to the loser after every transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_xfer) begin
      r_prio <= ~w_grant;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [33:0] sb[$];
  logic        prio_m = 1'b0;
  logic [1:0]  acc = 2'b00;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [31:0] exp_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000, 4'b0011, 4'b0110: return a + b;
      4'b0001: return (a != b) ? 32'd1 : 32'd0;
      4'b0010: return b;
      4'b0100: return b & 32'hFFFF_F000;
      4'b0101: return b & 32'h0000_00FF;
      4'b0111: return a << b[4:0];
      4'b1000: return a - b;
      4'b1001: return a >> b[4:0];
      4'b1010, 4'b1101: return a ^ b;
      4'b1011: return a | b;
      4'b1100: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: check handshake against the arbitration model, score outputs, record accepts.
  always @(negedge clk) begin
    logic       free_m, g_m;
    logic [1:0] rdy_m;
    logic [33:0] got, want;
    logic [31:0] r;
    if (!rst) begin
      free_m = !rsp_valid || rsp_ready;
      g_m    = (req_valid == 2'b11) ? prio_m : (req_valid == 2'b10);
      rdy_m  = (free_m && req_valid != 2'b00) ? (g_m ? 2'b10 : 2'b01) : 2'b00;
      chk_cnt++;
      if (req_ready !== rdy_m) $display("FAIL req_ready_model: got %b want %b at %0t", req_ready, rdy_m, $time);
      else pass_cnt++;
      if (rsp_valid && rsp_ready) begin
        got = {rsp_id, rsp_zero, rsp_result};
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL sb_unexpected: got %h want none at %0t", got, $time);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL sb_rsp: got %h want %h at %0t", got, want, $time);
          else pass_cnt++;
        end
      end
      if (rdy_m != 2'b00) begin
        r = g_m ? exp_alu(req1_ctrl, req1_srca, req1_srcb) : exp_alu(req0_ctrl, req0_srca, req0_srcb);
        sb.push_back({g_m, (r == 32'd0), r});
        prio_m = ~g_m;
      end
      acc = rdy_m;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb.delete();
    prio_m = 1'b0;
    acc = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    req0_srca = 0; req0_srcb = 0; req0_ctrl = 0;
    req1_srca = 0; req1_srcb = 0; req1_ctrl = 0;
    #1;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== 35'd0) $display("FAIL reset_outputs: got %b %b %b %h want 0", rsp_valid, rsp_id, rsp_zero, rsp_result);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready);
    else pass_cnt++;
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add;
    req_valid = 2'b01; req0_ctrl = 4'b0000; req0_srca = 5; req0_srcb = 7; rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd12})
      $display("FAIL add_rsp: got v%b id%b z%b %0d want v1 id0 z0 12", rsp_valid, rsp_id, rsp_zero, rsp_result);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_alternate;
    logic [31:0] want_r;
    do_reset();
    req0_ctrl = 4'b1000; req0_srca = 9; req0_srcb = 9;
    req1_ctrl = 4'b0000; req1_srca = 1; req1_srcb = 2;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      want_r = (k % 2 == 0) ? 32'd0 : 32'd3;
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== k[0] || rsp_result !== want_r || rsp_zero !== (want_r == 0))
        $display("FAIL alt_grant%0d: got v%b id%b %0d z%b want v1 id%0d %0d", k, rsp_valid, rsp_id, rsp_result, rsp_zero, k[0], want_r);
      else pass_cnt++;
    end
    req_valid = 2'b00;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL drain_clear: got %b want 0", rsp_valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stall;
    req_valid = 2'b01; req0_ctrl = 4'b0000; req0_srca = 20; req0_srcb = 22; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b10; req1_ctrl = 4'b1010; req1_srca = 32'hF0; req1_srcb = 32'h0F;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_cnt++;
      if (req_ready !== 2'b00) $display("FAIL stall_ready%0d: got %b want 00", k, req_ready);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd42})
        $display("FAIL stall_hold%0d: got v%b id%b z%b %0d want v1 id0 z0 42", k, rsp_valid, rsp_id, rsp_zero, rsp_result);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b10) $display("FAIL stall_release: got %b want 10", req_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'hFF)
      $display("FAIL stall_reload: got v%b id%b %h want v1 id1 ff", rsp_valid, rsp_id, rsp_result);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_req1_only;
    do_reset();
    req_valid = 2'b10; req1_ctrl = 4'b0100; req1_srca = 32'hDEAD; req1_srcb = 32'h12345678; rsp_ready = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b10) $display("FAIL req1_ready: got %b want 10", req_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'h12345000)
      $display("FAIL req1_lui: got id%b %h want id1 12345000", rsp_id, rsp_result);
    else pass_cnt++;
    req_valid = 2'b11; req0_ctrl = 4'b0010; req0_srcb = 32'h77;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01) $display("FAIL req1_prio_back: got %b want 01", req_ready);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_edges;
    req_valid = 2'b01; req0_ctrl = 4'b1111; req0_srca = 32'hFFFF_FFFF; req0_srcb = 32'h1234; rsp_ready = 1'b1;
    tick();
    chk_cnt++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1) $display("FAIL ctrl_invalid: got %h z%b want 0 z1", rsp_result, rsp_zero);
    else pass_cnt++;
    req0_ctrl = 4'b0000; req0_srca = 32'hFFFF_FFFF; req0_srcb = 32'd1;
    tick();
    chk_cnt++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b1) $display("FAIL add_wrap: got %h z%b want 0 z1", rsp_result, rsp_zero);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; req0_ctrl = 4'b1011; req0_srca = 32'h3; req0_srcb = 32'h4; rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || req_ready !== 2'b00)
      $display("FAIL reset_mid: got v%b %h rdy%b want v0 0 rdy00", rsp_valid, rsp_result, req_ready);
    else pass_cnt++;
    sb.delete();
    prio_m = 1'b0;
    acc = 2'b00;
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_no_emit: got %b want 0", rsp_valid);
    else pass_cnt++;
    req_valid = 2'b11;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01) $display("FAIL reset_prio: got %b want 01", req_ready);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 300; n++) begin
      if (!req_valid[0] || acc[0]) begin
        req_valid[0] = ($urandom_range(0, 3) != 0);
        req0_ctrl = 4'($urandom_range(0, 15));
        req0_srca = $urandom();
        req0_srcb = ($urandom_range(0, 7) == 0) ? req0_srca : $urandom();
      end
      if (!req_valid[1] || acc[1]) begin
        req_valid[1] = ($urandom_range(0, 3) != 0);
        req1_ctrl = 4'($urandom_range(0, 15));
        req1_srca = $urandom();
        req1_srcb = ($urandom_range(0, 7) == 0) ? req1_srca : $urandom();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alternate();
    test_stall();
    test_req1_only();
    test_edges();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
